fft_frame_streamer: RTL and testbench

Output-side companion to the `butterfly` FFT core. The core takes a whole 32-point complex frame in parallel and returns a whole 2048-bit frame. This block waits a fixed number of cycles for the core's result to settle, then captures that flat frame. It streams the frame out one 64-bit complex word per cycle over a valid/ready handshake, optionally in bit-reversed index order. It replaces the memory dump the bench performs today and is what the downstream consumers (result RAM, UART/DMA bridge) connect to.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_frame_streamer.sv | 121 ++++++++++++
 tb/tb_fft_frame_streamer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath blocks: frame geometry, the streamer
// FSM state type and the bit-reversal index permutation.
package fft_pkg;

    localparam int unsigned FFT_N     = 32;
    localparam int unsigned FFT_W     = 64;
    localparam int unsigned FFT_LOG2N = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM
    } state_e;

    // Reverse the low nbits bits of idx; bits above nbits come back as zero.
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < nbits) begin
                r[nbits-1-i] = idx[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_streamer.sv
// Captures a flat FFT result frame a fixed latency after start and streams it
// out one complex word per handshake, in natural or bit-reversed slot order.
module fft_frame_streamer
    import fft_pkg::*;
#(
    parameter int unsigned N       = FFT_N,
    parameter int unsigned W       = FFT_W,
    parameter int unsigned LATENCY = 8,
    parameter int unsigned BITREV  = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [N*W-1:0]         frame_in_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [W-1:0]           out_data_o,
    output logic [$clog2(N)-1:0]   out_index_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic                   frame_done_o
);

    localparam int unsigned LW = $clog2(N);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LW-1:0] LastIdx = LW'(N - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [LW-1:0]       idx_q, idx_d;
    logic [W-1:0]        data_q, data_d;
    logic                done_q, done_d;
    logic                capture;
    logic [N-1:0][W-1:0] frame_slots;
    logic [N-1:0][W-1:0] frame_q;

    assign frame_slots = frame_in_i;

    // Frame slot feeding output position i.
    function automatic logic [LW-1:0] src_of(input logic [LW-1:0] i);
        if (BITREV != 0) begin
            return LW'(bitrev(32'(i), LW));
        end
        return i;
    endfunction

    // Next-state logic; out_data is preloaded one word ahead so outputs stay registered.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        done_d     = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    wait_cnt_d = CW'(LATENCY - 1);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    // Buffer is written on this same edge, so take word 0 from the live frame.
                    data_d  = frame_slots[src_of('0)];
                    state_d = ST_STREAM;
                end else begin
                    wait_cnt_d = wait_cnt_q - CW'(1);
                end
            end
            ST_STREAM: begin
                if (out_ready_i) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        data_d  = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d  = idx_q + LW'(1);
                        data_d = frame_q[src_of(idx_q + LW'(1))];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    // Frame buffer; contents after reset are irrelevant, so it has no reset.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            frame_q <= frame_slots;
        end
    end

    assign out_valid_o  = (state_q == ST_STREAM);
    assign out_data_o   = data_q;
    assign out_index_o  = idx_q;
    assign out_last_o   = out_valid_o && (idx_q == LastIdx);
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed bench: natural / bit-reversed streaming, freeze and start rejection,
// backpressure, mid-stream reset and the LATENCY=1 corner.
module tb_fft_frame_streamer;

    localparam int unsigned N = 32;
    localparam int unsigned W = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           start_l1;
    logic           ready;
    logic           ready_l1;
    logic [N*W-1:0] frame_in;

    logic [W-1:0] n_data, r_data, l_data;
    logic [4:0]   n_idx, r_idx, l_idx;
    logic         n_valid, r_valid, l_valid;
    logic         n_last, r_last, l_last;
    logic         n_busy, r_busy, l_busy;
    logic         n_done, r_done, l_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_frame_streamer #(.N(N), .W(W), .LATENCY(8), .BITREV(0)) u_nat (
        .clk_i(clk), .reset_i(reset), .start_i(start), .frame_in_i(frame_in),
        .out_valid_o(n_valid), .out_ready_i(ready), .out_data_o(n_data),
        .out_index_o(n_idx), .out_last_o(n_last), .busy_o(n_busy), .frame_done_o(n_done)
    );

    fft_frame_streamer #(.N(N), .W(W), .LATENCY(8), .BITREV(1)) u_rev (
        .clk_i(clk), .reset_i(reset), .start_i(start), .frame_in_i(frame_in),
        .out_valid_o(r_valid), .out_ready_i(ready), .out_data_o(r_data),
        .out_index_o(r_idx), .out_last_o(r_last), .busy_o(r_busy), .frame_done_o(r_done)
    );

    fft_frame_streamer #(.N(N), .W(W), .LATENCY(1), .BITREV(0)) u_l1 (
        .clk_i(clk), .reset_i(reset), .start_i(start_l1), .frame_in_i(frame_in),
        .out_valid_o(l_valid), .out_ready_i(ready_l1), .out_data_o(l_data),
        .out_index_o(l_idx), .out_last_o(l_last), .busy_o(l_busy), .frame_done_o(l_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] slot_a(input int k);
        return {32'(k), 32'(32'h100 + k)};
    endfunction

    function automatic logic [63:0] slot_b(input int k);
        return {32'(32'hA000_0000 + k), 32'(32'hB000_0000 + k)};
    endfunction

    function automatic int brev5(input int k);
        int r;
        r = 0;
        for (int i = 0; i < 5; i++) r = r | (((k >> i) & 1) << (4 - i));
        return r;
    endfunction

    task automatic load_a();
        for (int k = 0; k < 32; k++) frame_in[k*64 +: 64] = slot_a(k);
    endtask

    task automatic load_b();
        for (int k = 0; k < 32; k++) frame_in[k*64 +: 64] = slot_b(k);
    endtask

    initial begin
        logic [63:0] held;
        logic        stalled;
        int          exp_k;
        int          cyc;
        int          rev_first [4];

        rev_first[0] = 0;
        rev_first[1] = 16;
        rev_first[2] = 8;
        rev_first[3] = 24;

        reset    = 1'b1;
        start    = 1'b0;
        start_l1 = 1'b0;
        ready    = 1'b1;
        ready_l1 = 1'b1;
        load_a();
        #1;
        tick();
        start = 1'b1;  // start coincident with reset must be ignored
        tick();
        start = 1'b0;
        reset = 1'b0;

        // Reset state
        check("rst_valid", 64'(n_valid), 64'(0));
        check("rst_busy",  64'(n_busy),  64'(0));
        check("rst_data",  64'(n_data),  64'(0));
        check("rst_index", 64'(n_idx),   64'(0));
        check("rst_last",  64'(n_last),  64'(0));
        check("rst_done",  64'(n_done),  64'(0));
        check("rst_l1_valid", 64'(l_valid), 64'(0));

        // Natural and bit-reversed order, ready held high; freeze and start rejection mid-stream
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        check("wait_valid", 64'(n_valid), 64'(0));
        check("wait_busy",  64'(n_busy),  64'(1));
        tick();
        check("nat_first_valid", 64'(n_valid), 64'(1));
        check("nat_first_data",  n_data, 64'h00000000_00000100);
        check("nat_first_index", 64'(n_idx), 64'(0));
        check("rev_pos0", r_data, slot_a(0));
        for (int k = 1; k < 32; k++) begin
            if (k == 5) begin
                load_b();
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            check("nat_data",  n_data, slot_a(k));
            check("nat_index", 64'(n_idx), 64'(k));
            check("nat_last",  64'(n_last), 64'(k == 31));
            check("rev_data",  r_data, slot_a(brev5(k)));
            if (k < 4) check("rev_pos_fixed", r_data, slot_a(rev_first[k]));
            check("done_low",  64'(n_done), 64'(0));
        end
        check("nat_word31", n_data, 64'h0000001F_0000011F);
        check("rev_pos31",  r_data, slot_a(31));
        tick();
        check("nat_done",      64'(n_done),  64'(1));
        check("rev_done",      64'(r_done),  64'(1));
        check("done_busy",     64'(n_busy),  64'(0));
        check("done_valid",    64'(n_valid), 64'(0));

        // Start in the frame_done cycle launches a new frame (frame_b now on the bus)
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", 64'(n_busy), 64'(1));
        check("restart_done", 64'(n_done), 64'(0));
        for (int c = 1; c < 8; c++) tick();
        check("bp_wait_valid", 64'(n_valid), 64'(0));
        tick();

        // Backpressure: ready pattern 1-0-0-1
        exp_k   = 0;
        stalled = 1'b0;
        held    = '0;
        cyc     = 0;
        while (exp_k < 32 && cyc < 200) begin
            ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (stalled) begin
                check("bp_stall_valid", 64'(n_valid), 64'(1));
                check("bp_stall_data",  n_data, held);
            end
            if (n_valid && ready) begin
                check("bp_data",  n_data, slot_b(exp_k));
                check("bp_index", 64'(n_idx), 64'(exp_k));
                check("bp_last",  64'(n_last), 64'(exp_k == 31));
                exp_k++;
                stalled = 1'b0;
            end else begin
                stalled = n_valid;
                held    = n_data;
            end
            tick();
            cyc++;
        end
        check("bp_handshakes", 64'(exp_k), 64'(32));
        check("bp_done", 64'(n_done), 64'(1));
        ready = 1'b1;

        // Reset mid-stream after handshake 10
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("mid_first_valid", 64'(n_valid), 64'(1));
        for (int c = 0; c < 10; c++) tick();
        check("mid_index10", 64'(n_idx), 64'(10));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", 64'(n_valid), 64'(0));
        check("mid_rst_data",  n_data,       64'(0));
        check("mid_rst_index", 64'(n_idx),   64'(0));
        check("mid_rst_busy",  64'(n_busy),  64'(0));
        check("mid_rst_done",  64'(n_done),  64'(0));
        check("mid_rst_rdata", r_data,       64'(0));
        tick();
        check("mid_no_done", 64'(n_done), 64'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        check("mid_again_wait", 64'(n_valid), 64'(0));
        tick();
        check("mid_again_valid", 64'(n_valid), 64'(1));
        check("mid_again_index", 64'(n_idx),   64'(0));
        check("mid_again_data",  n_data,       slot_b(0));

        // LATENCY=1 corner
        start_l1 = 1'b1;
        tick();
        start_l1 = 1'b0;
        check("l1_busy", 64'(l_busy), 64'(1));
        check("l1_valid_early", 64'(l_valid), 64'(0));
        tick();
        check("l1_valid", 64'(l_valid), 64'(1));
        check("l1_data",  l_data,       slot_b(0));
        check("l1_index", 64'(l_idx),   64'(0));
        tick();
        check("l1_data1", l_data, slot_b(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
